// File: rtl/pipe_result_collector.sv
// Receive-side collector for the 3-stage arithmetic pipeline.
// Results land in a first-word-fall-through FIFO and drain to the consumer over
// valid/ready. Issue credits account for results already buffered plus results
// still travelling through the pipeline, which has no stall path, so that a
// result is never dropped.
module pipe_result_collector #(
    parameter int N     = 10,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       issue_fire,
    input  logic                       in_valid,
    input  logic [N-1:0]               in_data,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [N-1:0]               out_data,
    output logic                       issue_ok,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic [$clog2(DEPTH+1)-1:0] inflight,
    output logic [CNT_W-1:0]           result_count,
    output logic                       overflow,
    output logic                       credit_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [N-1:0]     mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q, level_d;
    logic [LW-1:0]    inflight_q, inflight_d;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q, credit_err_q;

    logic             full, pop, push;
    logic [LW:0]      credit_sum;

    // Handshake qualifiers; a push into a full FIFO is allowed only when the
    // head leaves in the same cycle.
    always_comb begin
        full = (level_q == LW'(DEPTH));
        pop  = (level_q != '0) && out_ready;
        push = in_valid && (!full || pop);
    end

    // Next occupancy and in-flight count; in-flight saturates at both ends so a
    // misbehaving feeder or pipeline cannot wrap it.
    always_comb begin
        level_d = level_q;
        if (push && !pop)
            level_d = level_q + LW'(1);
        else if (pop && !push)
            level_d = level_q - LW'(1);

        inflight_d = inflight_q;
        if (issue_fire && !in_valid) begin
            if (inflight_q != '1)
                inflight_d = inflight_q + LW'(1);
        end else if (in_valid && !issue_fire) begin
            if (inflight_q != '0)
                inflight_d = inflight_q - LW'(1);
        end
    end

    // FIFO storage and pointers; pointers are exactly log2(DEPTH) bits so they
    // wrap on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_data;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    // Counters and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q      <= '0;
            inflight_q   <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            credit_err_q <= 1'b0;
        end else begin
            level_q    <= level_d;
            inflight_q <= inflight_d;
            if (pop)
                count_q <= count_q + CNT_W'(1);
            if (in_valid && full && !pop)
                overflow_q <= 1'b1;
            if (in_valid && (inflight_q == '0) && !issue_fire)
                credit_err_q <= 1'b1;
        end
    end

    // Credits are derived from registered counts only; the extra bit keeps the
    // sum from wrapping before the compare.
    always_comb begin
        credit_sum = {1'b0, level_q} + {1'b0, inflight_q};
        issue_ok   = (credit_sum < (LW+1)'(DEPTH));
    end

    assign out_valid    = (level_q != '0);
    assign out_data     = mem_q[rd_ptr_q];
    assign level        = level_q;
    assign inflight     = inflight_q;
    assign result_count = count_q;
    assign overflow     = overflow_q;
    assign credit_err   = credit_err_q;

endmodule
